stim_seq_gen: RTL
=================

STIM_SEQ_GEN -- requirements
Module: stim_seq_gen

Interface
REQ-001 Parameter WIDTH, default 2, stimulus vector width; legal range 1..16.
REQ-002 Parameter DIR_LEN, default 10, number of directed (counting) beats; legal range 0..65535.
REQ-003 Parameter RND_LEN, default 200, number of pseudo-random beats; legal range 0..65535.
REQ-004 Parameter SEED, default 16'hACE1, LFSR seed; must be nonzero (elaboration error if zero).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE or DONE.
REQ-008 ready  input  1  consumer accepts the current beat when ready=1 and stim_valid=1.
REQ-009 stim  output  WIDTH  stimulus vector driven to the block under test.
REQ-010 stim_valid  output  1  stim holds a beat to be consumed.
REQ-011 phase  output  2  current state: 0 IDLE, 1 DIRECTED, 2 RANDOM, 3 DONE.
REQ-012 done  output  1  high while in DONE.
REQ-013 sample_idx  output  16  count of beats accepted since the last start.

Function
REQ-014 FSM states IDLE, DIRECTED, RANDOM, DONE; registered outputs, no combinational path from inputs to outputs.
REQ-015 IDLE/DONE + start -> DIRECTED next cycle (RANDOM if DIR_LEN=0; DONE if both lengths 0); sample_idx cleared to 0, LFSR reloaded with SEED.
REQ-016 start in DIRECTED or RANDOM: ignored, no effect.
REQ-017 DIRECTED: first beat stim=0; each accepted beat increments stim modulo 2^WIDTH.
REQ-018 After DIR_LEN accepted directed beats -> RANDOM in the same cycle as the last acceptance; first random beat stim=SEED[WIDTH-1:0].
REQ-019 RANDOM: stim = LFSR[WIDTH-1:0]; LFSR is 16-bit Galois, right shift, feedback mask 16'hB400, advancing exactly once per accepted random beat.
REQ-020 After RND_LEN accepted random beats -> DONE; stim_valid=0, done=1; stim holds its last value.
REQ-021 stim_valid=1 throughout DIRECTED and RANDOM; stim, phase and LFSR remain stable while ready=0 (backpressure, no beat lost or duplicated).
REQ-022 sample_idx increments by 1 per accepted beat, saturates at 16'hFFFF.
REQ-023 start and the final acceptance of RANDOM in the same cycle: the acceptance completes, start is ignored, FSM enters DONE.

Reset
REQ-024 rst_n low asynchronously forces IDLE: stim=0, stim_valid=0, done=0, phase=0, sample_idx=0, LFSR=SEED.
REQ-025 Reset asserted mid-sequence aborts it; after release the block waits in IDLE for start.
REQ-026 Reset release is synchronised on clk before affecting the FSM (two-stage synchroniser; assertion stays asynchronous).

Structure
REQ-027 Shared package stim_pkg holds the phase enum (IDLE/DIRECTED/RANDOM/DONE) and the LFSR feedback-mask constant 16'hB400.
REQ-028 One sub-module, lfsr16, with load (SEED), advance enable and 16-bit state output; FSM and counters live in stim_seq_gen.

Verification
REQ-029 Defaults, ready=1, start pulse -> 10 directed beats stim 0,1,2,3,0,1,2,3,0,1 with phase=1, then phase=2.
REQ-030 First two random beats (defaults) -> stim=2'b01 (SEED low bits), then 2'b00 (LFSR 16'hE270); after 200 random beats done=1, stim_valid=0, sample_idx=210.
REQ-031 ready held 0 for 5 cycles at directed beat 3 -> stim stays 3, sample_idx stays 3, sequence resumes without gap or repeat.
REQ-032 rst_n pulsed low during RANDOM at sample_idx=50 -> all outputs immediately at reset values; new start reproduces the identical beat sequence.
REQ-033 DIR_LEN=0, RND_LEN=4 -> start goes straight to phase=2, exactly 4 beats, done=1; start in DONE restarts with sample_idx=0.
REQ-034 start pulsed during DIRECTED at beat 5 -> ignored; beat sequence and sample_idx unchanged.

Source files
------------

// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared phase encoding and LFSR step function for the stimulus generator
package stim_pkg;

    typedef enum logic [1:0] {
        PHASE_IDLE     = 2'd0,
        PHASE_DIRECTED = 2'd1,
        PHASE_RANDOM   = 2'd2,
        PHASE_DONE     = 2'd3
    } phase_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Galois form, right shift: the bit shifted out selects the feedback mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/stim_seq_gen_if.sv
// rtl/stim_seq_gen_if.sv - stimulus beat handshake between generator and consumer
interface stim_seq_gen_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] stim;
    logic             stim_valid;
    logic             ready;

    modport master (output stim, output stim_valid, input ready);
    modport slave  (input stim, input stim_valid, output ready);
endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with synchronous seed load and advance enable
module lfsr16
    import stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/stim_seq_gen.sv
// rtl/stim_seq_gen.sv - directed-then-random stimulus sequencer with ready/valid backpressure
module stim_seq_gen
    import stim_pkg::*;
#(
    parameter int          WIDTH   = 2,
    parameter int          DIR_LEN = 10,
    parameter int          RND_LEN = 200,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    stim_seq_gen_if.master        stim_bus,
    output logic [1:0]            phase,
    output logic                  done,
    output logic [15:0]           sample_idx
);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("stim_seq_gen: SEED must be nonzero");
    end
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("stim_seq_gen: WIDTH must be 1..16");
    end
    if (DIR_LEN < 0 || DIR_LEN > 65535 || RND_LEN < 0 || RND_LEN > 65535) begin : g_bad_len
        $error("stim_seq_gen: DIR_LEN and RND_LEN must be 0..65535");
    end

    localparam logic [15:0] DIR_LAST = (DIR_LEN == 0) ? 16'd0 : 16'(DIR_LEN - 1);
    localparam logic [15:0] RND_LAST = (RND_LEN == 0) ? 16'd0 : 16'(RND_LEN - 1);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    phase_e           state;
    logic [WIDTH-1:0] stim_q;
    logic             valid_q;
    logic             done_q;
    logic [15:0]      idx_q;
    logic [15:0]      beat_cnt;
    logic [15:0]      lfsr_state;
    logic [15:0]      lfsr_next;
    logic             unused_lfsr;
    logic             accept;
    logic             can_start;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic [15:0]      idx_inc;

    // Assertion reaches the FSM immediately; release is delayed two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    assign accept    = valid_q & stim_bus.ready;
    assign can_start = (state == PHASE_IDLE) || (state == PHASE_DONE);
    assign lfsr_load = start & can_start;
    assign lfsr_adv  = accept & (state == PHASE_RANDOM);
    assign lfsr_next = lfsr_step(lfsr_state);
    assign unused_lfsr = ^lfsr_next;
    assign idx_inc   = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= PHASE_IDLE;
            stim_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= 16'd0;
            beat_cnt <= 16'd0;
        end else begin
            case (state)
                PHASE_IDLE, PHASE_DONE: begin
                    if (start) begin
                        idx_q    <= 16'd0;
                        beat_cnt <= 16'd0;
                        if (DIR_LEN != 0) begin
                            state   <= PHASE_DIRECTED;
                            stim_q  <= '0;
                            valid_q <= 1'b1;
                            done_q  <= 1'b0;
                        end else if (RND_LEN != 0) begin
                            state   <= PHASE_RANDOM;
                            stim_q  <= SEED[WIDTH-1:0];
                            valid_q <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state   <= PHASE_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                PHASE_DIRECTED: begin
                    if (accept) begin
                        idx_q <= idx_inc;
                        if (beat_cnt == DIR_LAST) begin
                            beat_cnt <= 16'd0;
                            if (RND_LEN != 0) begin
                                // LFSR was reloaded at start and has not moved yet
                                state  <= PHASE_RANDOM;
                                stim_q <= lfsr_state[WIDTH-1:0];
                            end else begin
                                state   <= PHASE_DONE;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                            stim_q   <= stim_q + 1'b1;
                        end
                    end
                end
                PHASE_RANDOM: begin
                    if (accept) begin
                        idx_q <= idx_inc;
                        if (beat_cnt == RND_LAST) begin
                            state   <= PHASE_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                            stim_q   <= lfsr_next[WIDTH-1:0];
                        end
                    end
                end
                default: state <= PHASE_IDLE;
            endcase
        end
    end

    assign stim_bus.stim       = stim_q;
    assign stim_bus.stim_valid = valid_q;
    assign phase               = state;
    assign done                = done_q;
    assign sample_idx          = idx_q;

endmodule
